// File: rtl/bp_pkg.sv
// Shared types and constants for the bimodal branch predictor.
// Holds the branch opcode, the 2-bit counter encoding, the default geometry,
// the BTB entry layout at that geometry, and the saturating counter step.
package bp_pkg;

  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

  localparam int unsigned BP_XLEN    = 32;
  localparam int unsigned BP_ENTRIES = 64;
  localparam int unsigned BP_IDX     = $clog2(BP_ENTRIES);
  localparam int unsigned BP_TAG_W   = BP_XLEN - BP_IDX - 2;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_e;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_XLEN-1:0]  target;
    bp_ctr_e             ctr;
  } btb_entry_t;

  // Saturating step: ST stays ST on taken, SNT stays SNT on not-taken.
  function automatic bp_ctr_e ctr_next(input bp_ctr_e cur, input logic taken);
    bp_ctr_e res;
    res = cur;
    if (taken) begin
      if (cur != ST) res = bp_ctr_e'(2'(cur) + 2'd1);
    end else begin
      if (cur != SNT) res = bp_ctr_e'(2'(cur) - 2'd1);
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_bimodal_btb_btb.sv
// BTB storage: direct-mapped flop array with synchronous reset clear.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   rd0_*                        asynchronous lookup port used by IF
//   rd1_*                        asynchronous lookup port used by the EX update
//   wr_en/wr_idx/wr_tag/...      synchronous write port (sets valid)
// Reset clears every valid bit and loads CTR_INIT into every counter;
// tags and targets are left as-is since valid gates their use.
module bp_btb
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES  = BP_ENTRIES,
  parameter int unsigned XLEN     = BP_XLEN,
  parameter logic [1:0]  CTR_INIT = 2'b01,
  localparam int unsigned IDX     = $clog2(ENTRIES),
  localparam int unsigned TAG_W   = XLEN - IDX - 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX-1:0]   rd0_idx,
  output logic             rd0_valid,
  output logic [TAG_W-1:0] rd0_tag,
  output logic [XLEN-1:0]  rd0_target,
  output bp_ctr_e          rd0_ctr,
  input  logic [IDX-1:0]   rd1_idx,
  output logic             rd1_valid,
  output logic [TAG_W-1:0] rd1_tag,
  output logic [XLEN-1:0]  rd1_target,
  output bp_ctr_e          rd1_ctr,
  input  logic             wr_en,
  input  logic [IDX-1:0]   wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [XLEN-1:0]  wr_target,
  input  bp_ctr_e          wr_ctr
);

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  bp_ctr_e          ctr_q    [ENTRIES];

  // Valid and counter state: cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= bp_ctr_e'(CTR_INIT);
      end
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
      ctr_q[wr_idx]   <= wr_ctr;
    end
  end

  // Payload: no reset needed, qualified by valid.
  always_ff @(posedge clk_i) begin
    if (wr_en && !rst_i) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
    end
  end

  // Reads return pre-write contents; no write-to-read bypass.
  assign rd0_valid  = valid_q[rd0_idx];
  assign rd0_tag    = tag_q[rd0_idx];
  assign rd0_target = target_q[rd0_idx];
  assign rd0_ctr    = ctr_q[rd0_idx];

  assign rd1_valid  = valid_q[rd1_idx];
  assign rd1_tag    = tag_q[rd1_idx];
  assign rd1_target = target_q[rd1_idx];
  assign rd1_ctr    = ctr_q[rd1_idx];

endmodule

// File: rtl/bp_bimodal_btb.sv
// Bimodal dynamic branch predictor with a direct-mapped BTB.
// IF: predicts direction/target of conditional branches from the BTB.
// EX: resolves the branch, raises flush_br/redirect_pc on a mispredict and
//     updates the 2-bit saturating counter / target of the entry.
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   predictor_en               0 selects static not-taken with a frozen table
//   pc_IF, instr_IF            fetch PC and instruction
//   pred_taken_IF, npc, hit    IF prediction outputs (combinational)
//   pc_EX, instr_EX            instruction being resolved
//   pred_taken_EX/target_EX    prediction that travelled with it
//   pc_sel_EX, aludata_EX      resolved direction and target
//   flush_br, redirect_pc      mispredict recovery (combinational)
//   perf_br_cnt_o/misp_cnt_o   saturating event counters, only with BP_PERF_EN
// Build option: define BP_PERF_EN to add the performance counters.
module bp_bimodal_btb
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES  = BP_ENTRIES,
  parameter int unsigned XLEN     = BP_XLEN,
  parameter logic [1:0]  CTR_INIT = 2'b01
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            predictor_en,
  input  logic [XLEN-1:0] pc_IF,
  input  logic [31:0]     instr_IF,
  output logic            pred_taken_IF,
  output logic [XLEN-1:0] npc,
  input  logic [XLEN-1:0] pc_EX,
  input  logic [31:0]     instr_EX,
  input  logic            pred_taken_EX,
  input  logic [XLEN-1:0] pred_target_EX,
  input  logic            pc_sel_EX,
  input  logic [XLEN-1:0] aludata_EX,
  output logic            flush_br,
  output logic [XLEN-1:0] redirect_pc,
  output logic            hit
`ifdef BP_PERF_EN
  ,
  output logic [31:0]     perf_br_cnt_o,
  output logic [31:0]     perf_misp_cnt_o
`endif
);

  localparam int unsigned IDX   = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX - 2;

  logic [IDX-1:0]   if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_valid, ex_valid;
  logic [TAG_W-1:0] if_tag_rd, ex_tag_rd;
  logic [XLEN-1:0]  if_target, ex_target;
  bp_ctr_e          if_ctr, ex_ctr;

  logic             is_br, ex_br, ex_hit, mispredict;
  logic             wr_en;
  bp_ctr_e          wr_ctr;
  logic [XLEN-1:0]  wr_target;

  assign if_idx = pc_IF[IDX+1:2];
  assign if_tag = pc_IF[XLEN-1:IDX+2];
  assign ex_idx = pc_EX[IDX+1:2];
  assign ex_tag = pc_EX[XLEN-1:IDX+2];

  bp_btb #(
    .ENTRIES  (ENTRIES),
    .XLEN     (XLEN),
    .CTR_INIT (CTR_INIT)
  ) u_btb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd0_idx    (if_idx),
    .rd0_valid  (if_valid),
    .rd0_tag    (if_tag_rd),
    .rd0_target (if_target),
    .rd0_ctr    (if_ctr),
    .rd1_idx    (ex_idx),
    .rd1_valid  (ex_valid),
    .rd1_tag    (ex_tag_rd),
    .rd1_target (ex_target),
    .rd1_ctr    (ex_ctr),
    .wr_en      (wr_en),
    .wr_idx     (ex_idx),
    .wr_tag     (ex_tag),
    .wr_target  (wr_target),
    .wr_ctr     (wr_ctr)
  );

  // IF lookup and prediction.
  always_comb begin
    is_br         = (instr_IF[6:0] == OPC_BRANCH);
    hit           = 1'b0;
    pred_taken_IF = 1'b0;
    npc           = pc_IF + XLEN'(4);
    if (!rst_i && predictor_en && is_br && if_valid && (if_tag_rd == if_tag)) begin
      hit           = 1'b1;
      pred_taken_IF = if_ctr[1];
      if (if_ctr[1]) npc = if_target;
    end
  end

  // EX resolve; still active with the predictor disabled.
  always_comb begin
    ex_br       = (instr_EX[6:0] == OPC_BRANCH);
    mispredict  = ex_br && ((pc_sel_EX != pred_taken_EX) ||
                            (pc_sel_EX && pred_taken_EX && (aludata_EX != pred_target_EX)));
    flush_br    = mispredict && !rst_i;
    redirect_pc = (pc_sel_EX && !rst_i) ? aludata_EX : pc_EX + XLEN'(4);
  end

  // Table update from EX: train on hit, allocate only on a taken miss.
  always_comb begin
    ex_hit    = ex_valid && (ex_tag_rd == ex_tag);
    wr_en     = 1'b0;
    wr_ctr    = WT;
    wr_target = aludata_EX;
    if (predictor_en && ex_br && !rst_i) begin
      if (ex_hit) begin
        wr_en  = 1'b1;
        wr_ctr = ctr_next(ex_ctr, pc_sel_EX);
        if (!pc_sel_EX) wr_target = ex_target;
      end else if (pc_sel_EX) begin
        wr_en = 1'b1;
      end
    end
  end

`ifdef BP_PERF_EN
  logic [31:0] br_cnt_q, misp_cnt_q;

  // Saturating branch / mispredict event counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_cnt_q   <= 32'd0;
      misp_cnt_q <= 32'd0;
    end else if (predictor_en && ex_br) begin
      if (br_cnt_q != 32'hFFFF_FFFF) br_cnt_q <= br_cnt_q + 32'd1;
      if (flush_br && (misp_cnt_q != 32'hFFFF_FFFF)) misp_cnt_q <= misp_cnt_q + 32'd1;
    end
  end

  assign perf_br_cnt_o   = br_cnt_q;
  assign perf_misp_cnt_o = misp_cnt_q;
`endif

  // Byte-offset and non-opcode instruction bits play no part in prediction.
  logic unused_bits;
  assign unused_bits = ^{pc_IF[1:0], pc_EX[1:0], instr_IF[31:7], instr_EX[31:7]};

endmodule

// File: tb/tb_bp_bimodal_btb.sv
// Self-checking bench for bp_bimodal_btb: directed vectors with literal
// expectations, plus a table model checked against the DUT every cycle.
module tb_bp_bimodal_btb;

  localparam int unsigned ENTRIES = 64;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned IDXW    = 6;
  localparam logic [31:0] BR      = 32'h0000_0063;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, predictor_en;
  logic [31:0] pc_IF, instr_IF, pc_EX, instr_EX, pred_target_EX, aludata_EX;
  logic        pred_taken_EX, pc_sel_EX;
  logic        pred_taken_IF, flush_br, hit;
  logic [31:0] npc, redirect_pc;

  bp_bimodal_btb #(
    .ENTRIES  (ENTRIES),
    .XLEN     (XLEN),
    .CTR_INIT (2'b01)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .predictor_en   (predictor_en),
    .pc_IF          (pc_IF),
    .instr_IF       (instr_IF),
    .pred_taken_IF  (pred_taken_IF),
    .npc            (npc),
    .pc_EX          (pc_EX),
    .instr_EX       (instr_EX),
    .pred_taken_EX  (pred_taken_EX),
    .pred_target_EX (pred_target_EX),
    .pc_sel_EX      (pc_sel_EX),
    .aludata_EX     (aludata_EX),
    .flush_br       (flush_br),
    .redirect_pc    (redirect_pc),
    .hit            (hit)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per-index entry, counter kept as an integer 0..3.
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];

  always @(negedge clk) begin : compare
    int unsigned ii, ie, tif, tex;
    bit e_hit, e_pt, ex_is_br, misp, e_flush;
    logic [31:0] e_npc, e_redir;
    ii  = (pc_IF >> 2) % ENTRIES;
    tif = pc_IF >> (IDXW + 2);
    ie  = (pc_EX >> 2) % ENTRIES;
    tex = pc_EX >> (IDXW + 2);

    e_hit = !rst_i && predictor_en && (instr_IF[6:0] == 7'h63) &&
            m_valid[ii] && (m_tag[ii] == tif);
    e_pt  = e_hit && (m_ctr[ii] >= 2);
    e_npc = e_pt ? m_target[ii] : 32'(pc_IF + 32'd4);

    ex_is_br = (instr_EX[6:0] == 7'h63);
    misp     = ex_is_br && ((pc_sel_EX != pred_taken_EX) ||
                            (pc_sel_EX && pred_taken_EX && aludata_EX != pred_target_EX));
    e_flush  = !rst_i && misp;
    e_redir  = (!rst_i && pc_sel_EX) ? aludata_EX : 32'(pc_EX + 32'd4);

    chk("cmp_hit",      32'(hit),           32'(e_hit));
    chk("cmp_pred",     32'(pred_taken_IF), 32'(e_pt));
    chk("cmp_npc",      npc,                e_npc);
    chk("cmp_flush",    32'(flush_br),      32'(e_flush));
    chk("cmp_redirect", redirect_pc,        e_redir);

    if (rst_i) begin
      for (int k = 0; k < ENTRIES; k++) begin
        m_valid[k] = 1'b0;
        m_ctr[k]   = 1;
      end
    end else if (predictor_en && ex_is_br) begin
      if (m_valid[ie] && m_tag[ie] == tex) begin
        if (pc_sel_EX) begin
          m_ctr[ie]    = (m_ctr[ie] == 3) ? 3 : m_ctr[ie] + 1;
          m_target[ie] = aludata_EX;
        end else begin
          m_ctr[ie] = (m_ctr[ie] == 0) ? 0 : m_ctr[ie] - 1;
        end
      end else if (pc_sel_EX) begin
        m_valid[ie]  = 1'b1;
        m_tag[ie]    = tex;
        m_target[ie] = aludata_EX;
        m_ctr[ie]    = 2;
      end
    end
  end

  // Apply one cycle of inputs just after posedge; return just after negedge.
  task automatic drive(input logic r, input logic en,
                       input logic [31:0] pif, input logic [31:0] iif,
                       input logic [31:0] pex, input logic [31:0] iex,
                       input logic pt, input logic [31:0] ptg,
                       input logic sel, input logic [31:0] alu);
    @(posedge clk);
    #1;
    rst_i = r; predictor_en = en;
    pc_IF = pif; instr_IF = iif;
    pc_EX = pex; instr_EX = iex;
    pred_taken_EX = pt; pred_target_EX = ptg;
    pc_sel_EX = sel; aludata_EX = alu;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; predictor_en = 1'b1;
    pc_IF = 32'h0; instr_IF = NOP;
    pc_EX = 32'h0; instr_EX = NOP;
    pred_taken_EX = 1'b0; pred_target_EX = 32'h0;
    pc_sel_EX = 1'b0; aludata_EX = 32'h0;

    // Reset with a taken branch in EX: dropped, no flush.
    drive(1, 1, 32'h100, BR, 32'h100, BR, 0, 32'h104, 1, 32'h180);
    chk("rst_flush", 32'(flush_br), 32'h0);
    chk("rst_hit", 32'(hit), 32'h0);
    chk("rst_npc", npc, 32'h104);
    chk("rst_redirect", redirect_pc, 32'h104);
    drive(1, 1, 32'h0, NOP, 32'h0, NOP, 0, 32'h0, 0, 32'h0);

    // 1: cold miss, then taken resolve allocates WT.
    drive(0, 1, 32'h100, BR, 32'h0, NOP, 0, 32'h0, 0, 32'h0);
    chk("t1_hit", 32'(hit), 32'h0);
    chk("t1_npc", npc, 32'h104);
    drive(0, 1, 32'h0, NOP, 32'h100, BR, 0, 32'h104, 1, 32'h180);
    chk("t1_flush", 32'(flush_br), 32'h1);
    chk("t1_redirect", redirect_pc, 32'h180);

    // 2: predicted taken, correct -> ST, then ST stays ST.
    drive(0, 1, 32'h100, BR, 32'h100, BR, 1, 32'h180, 1, 32'h180);
    chk("t2_hit", 32'(hit), 32'h1);
    chk("t2_pred", 32'(pred_taken_IF), 32'h1);
    chk("t2_npc", npc, 32'h180);
    chk("t2_flush", 32'(flush_br), 32'h0);
    drive(0, 1, 32'h100, BR, 32'h100, BR, 1, 32'h180, 1, 32'h180);
    chk("t2_flush_st", 32'(flush_br), 32'h0);

    // 3: two not-taken resolves: ST -> WT -> WNT.
    drive(0, 1, 32'h0, NOP, 32'h100, BR, 1, 32'h180, 0, 32'h180);
    chk("t3_flush1", 32'(flush_br), 32'h1);
    chk("t3_redirect1", redirect_pc, 32'h104);
    drive(0, 1, 32'h100, BR, 32'h0, NOP, 0, 32'h0, 0, 32'h0);
    chk("t3_pred_wt", 32'(pred_taken_IF), 32'h1);
    drive(0, 1, 32'h0, NOP, 32'h100, BR, 1, 32'h180, 0, 32'h180);
    chk("t3_flush2", 32'(flush_br), 32'h1);
    drive(0, 1, 32'h100, BR, 32'h0, NOP, 0, 32'h0, 0, 32'h0);
    chk("t3_hit_wnt", 32'(hit), 32'h1);
    chk("t3_pred_wnt", 32'(pred_taken_IF), 32'h0);
    chk("t3_npc_wnt", npc, 32'h104);

    // 4: aliasing 0x200 evicts 0x100.
    drive(0, 1, 32'h0, NOP, 32'h200, BR, 0, 32'h204, 1, 32'h280);
    chk("t4_flush", 32'(flush_br), 32'h1);
    chk("t4_redirect", redirect_pc, 32'h280);
    drive(0, 1, 32'h100, BR, 32'h0, NOP, 0, 32'h0, 0, 32'h0);
    chk("t4_alias_miss", 32'(hit), 32'h0);
    chk("t4_alias_npc", npc, 32'h104);
    // Same-index IF read and EX write: IF sees the old target.
    drive(0, 1, 32'h200, BR, 32'h200, BR, 1, 32'h280, 1, 32'h2C0);
    chk("t4_nobypass_npc", npc, 32'h280);
    chk("t4_tgt_flush", 32'(flush_br), 32'h1);
    chk("t4_tgt_redirect", redirect_pc, 32'h2C0);
    drive(0, 1, 32'h200, BR, 32'h0, NOP, 0, 32'h0, 0, 32'h0);
    chk("t4_new_npc", npc, 32'h2C0);

    // 5: target change 0x180 -> 0x1C0.
    drive(0, 1, 32'h0, NOP, 32'h100, BR, 0, 32'h104, 1, 32'h180);
    drive(0, 1, 32'h0, NOP, 32'h100, BR, 1, 32'h180, 1, 32'h1C0);
    chk("t5_flush", 32'(flush_br), 32'h1);
    chk("t5_redirect", redirect_pc, 32'h1C0);
    drive(0, 1, 32'h100, BR, 32'h0, NOP, 0, 32'h0, 0, 32'h0);
    chk("t5_npc", npc, 32'h1C0);

    // 6: predictor disabled: flush still raised, table frozen.
    drive(0, 0, 32'h100, BR, 32'h100, BR, 0, 32'h104, 1, 32'h300);
    chk("t6_flush", 32'(flush_br), 32'h1);
    chk("t6_redirect", redirect_pc, 32'h300);
    chk("t6_hit_dis", 32'(hit), 32'h0);
    chk("t6_npc_dis", npc, 32'h104);
    drive(0, 1, 32'h100, BR, 32'h0, NOP, 0, 32'h0, 0, 32'h0);
    chk("t6_frozen_npc", npc, 32'h1C0);

    // Non-branch in EX never flushes; not-taken miss does not allocate.
    drive(0, 1, 32'h0, NOP, 32'h100, NOP, 0, 32'h0, 1, 32'h500);
    chk("nb_flush", 32'(flush_br), 32'h0);
    drive(0, 1, 32'h0, NOP, 32'h300, BR, 0, 32'h304, 0, 32'h380);
    chk("nt_miss_flush", 32'(flush_br), 32'h0);
    drive(0, 1, 32'h300, BR, 32'h0, NOP, 0, 32'h0, 0, 32'h0);
    chk("nt_miss_hit", 32'(hit), 32'h0);

    // PC+4 wraps.
    drive(0, 1, 32'hFFFF_FFFC, NOP, 32'hFFFF_FFFC, BR, 1, 32'h0, 0, 32'h0);
    chk("wrap_npc", npc, 32'h0);
    chk("wrap_redirect", redirect_pc, 32'h0);

    // Reset mid-stream, then the entry is gone.
    drive(1, 1, 32'h100, BR, 32'h100, BR, 0, 32'h104, 1, 32'h400);
    chk("rst2_flush", 32'(flush_br), 32'h0);
    chk("rst2_redirect", redirect_pc, 32'h104);
    drive(0, 1, 32'h100, BR, 32'h0, NOP, 0, 32'h0, 0, 32'h0);
    chk("rst2_miss", 32'(hit), 32'h0);
    chk("rst2_npc", npc, 32'h104);

    drive(0, 1, 32'h0, NOP, 32'h0, NOP, 0, 32'h0, 0, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
